// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response bundle between two requesters, the arbiter and Memory33.
// Ports m0_* and m1_* belong to the requesters. Port 0 is the pipeline and port 1 the secondary master.
// mem_* is the shared Memory33 port.
// The slave modport is the arbiter's view. The master modport is the surrounding system's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  m0_valid, m0_write, m0_wgrubby;
    logic [3:0]            m0_wmask;
    logic [31:0]           m0_wdata;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_ready, m0_rvalid, m0_rgrubby;
    logic [31:0]           m0_rdata;
    logic                  m1_valid, m1_write, m1_wgrubby;
    logic [3:0]            m1_wmask;
    logic [31:0]           m1_wdata;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic                  m1_ready, m1_rvalid, m1_rgrubby;
    logic [31:0]           m1_rdata;
    logic                  mem_valid, mem_write, mem_wgrubby, mem_rgrubby;
    logic [3:0]            mem_wmask;
    logic [31:0]           mem_wdata, mem_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;

    modport slave (
        input  m0_valid, m0_write, m0_wmask, m0_wdata, m0_wgrubby, m0_addr,
        output m0_ready, m0_rvalid, m0_rdata, m0_rgrubby,
        input  m1_valid, m1_write, m1_wmask, m1_wdata, m1_wgrubby, m1_addr,
        output m1_ready, m1_rvalid, m1_rdata, m1_rgrubby,
        output mem_valid, mem_write, mem_wmask, mem_wdata, mem_wgrubby, mem_addr,
        input  mem_rdata, mem_rgrubby
    );

    modport master (
        output m0_valid, m0_write, m0_wmask, m0_wdata, m0_wgrubby, m0_addr,
        input  m0_ready, m0_rvalid, m0_rdata, m0_rgrubby,
        output m1_valid, m1_write, m1_wmask, m1_wdata, m1_wgrubby, m1_addr,
        input  m1_ready, m1_rvalid, m1_rdata, m1_rgrubby,
        input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_wgrubby, mem_addr,
        output mem_rdata, mem_rgrubby
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares single-port Memory33 between two requesters.
// Port 0 has fixed priority. A starvation guard forces port 1 through after MAX_WAIT refusals.
// Ports: clk, rst (sync, active-high) and bus (mem_port_arbiter_if.slave).
// The bus carries the m0_*/m1_* requester ports and the mem_* memory port.
// Read data arrives one cycle after grant and is routed to the requester that owned the read.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int WAIT_BITS  = 3
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [WAIT_BITS-1:0] MAX_W = WAIT_BITS'(MAX_WAIT);

    logic [WAIT_BITS-1:0] wait_cnt;
    logic                 force1, grant0, grant1, q_rd0, q_rd1;

    // Port 1 wins when port 0 is idle, or when it has waited MAX_WAIT cycles.
    assign force1 = (MAX_WAIT != 0) && (wait_cnt == MAX_W);
    assign grant1 = !rst && bus.m1_valid && (!bus.m0_valid || force1);
    assign grant0 = !rst && bus.m0_valid && !grant1;

    assign bus.m0_ready = grant0;
    assign bus.m1_ready = grant1;

    // With no grant every mem_* output is zero, so a refused write never reaches memory.
    assign bus.mem_valid   = grant0 || grant1;
    assign bus.mem_write   = grant1 ? bus.m1_write   : grant0 && bus.m0_write;
    assign bus.mem_wgrubby = grant1 ? bus.m1_wgrubby : grant0 && bus.m0_wgrubby;
    assign bus.mem_wmask   = grant1 ? bus.m1_wmask   : grant0 ? bus.m0_wmask : '0;
    assign bus.mem_wdata   = grant1 ? bus.m1_wdata   : grant0 ? bus.m0_wdata : '0;
    assign bus.mem_addr    = grant1 ? bus.m1_addr    : grant0 ? bus.m0_addr  : '0;

    assign bus.m0_rvalid  = q_rd0;
    assign bus.m1_rvalid  = q_rd1;
    assign bus.m0_rdata   = q_rd0 ? bus.mem_rdata : '0;
    assign bus.m1_rdata   = q_rd1 ? bus.mem_rdata : '0;
    assign bus.m0_rgrubby = q_rd0 && bus.mem_rgrubby;
    assign bus.m1_rgrubby = q_rd1 && bus.mem_rgrubby;

    // Counts consecutive refusals of a pending port 1 request. It saturates at MAX_WAIT.
    // With MAX_WAIT=0 it stays at zero.
    always_ff @(posedge clk) begin
        if (rst || grant1 || !bus.m1_valid)
            wait_cnt <= '0;
        else if (wait_cnt != MAX_W)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Owner of the read now in flight. Grants are already forced low during rst, so a pending response is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_rd0 <= 1'b0;
            q_rd1 <= 1'b0;
        end else begin
            q_rd0 <= grant0 && !bus.m0_write;
            q_rd1 <= grant1 && !bus.m1_write;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (MAX_WAIT=4 and MAX_WAIT=0 instances).
module tb_mem_port_arbiter;
    typedef struct {
        bit          port;
        logic [31:0] data;
        logic        grubby;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rsp_t        sb[$];
    logic [31:0] ref_mem [256];
    logic        ref_g   [256];
    logic [31:0] mem     [256];
    logic        mem_g   [256];
    bit          mem_init = 1'b0;
    int          wc0 = 0;
    int          wc1 = 0;
    logic        g0_m, g1_m, obs_g1_u0, obs_g1_u1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32)) b0 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(32)) b1 ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .MAX_WAIT(4), .WAIT_BITS(3)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    mem_port_arbiter #(.ADDR_WIDTH(32), .MAX_WAIT(0), .WAIT_BITS(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    assign b1.m0_valid   = b0.m0_valid;
    assign b1.m0_write   = b0.m0_write;
    assign b1.m0_wmask   = b0.m0_wmask;
    assign b1.m0_wdata   = b0.m0_wdata;
    assign b1.m0_wgrubby = b0.m0_wgrubby;
    assign b1.m0_addr    = b0.m0_addr;
    assign b1.m1_valid   = b0.m1_valid;
    assign b1.m1_write   = b0.m1_write;
    assign b1.m1_wmask   = b0.m1_wmask;
    assign b1.m1_wdata   = b0.m1_wdata;
    assign b1.m1_wgrubby = b0.m1_wgrubby;
    assign b1.m1_addr    = b0.m1_addr;
    assign b1.mem_rdata   = 32'h0;
    assign b1.mem_rgrubby = 1'b0;

    // Memory33 stand-in: one-cycle read latency. It returns junk when no read is in flight.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]   <= 32'h0;
                mem_g[i] <= 1'b0;
            end
            mem[8'h80]   <= 32'h12345678;
            mem_g[8'h80] <= 1'b1;
            mem[8'h81]   <= 32'h0BADF00D;
            mem_init     <= 1'b1;
            b0.mem_rdata   <= 32'hA5A5A5A5;
            b0.mem_rgrubby <= 1'b1;
        end else if (b0.mem_valid && !b0.mem_write) begin
            b0.mem_rdata   <= mem[b0.mem_addr[9:2]];
            b0.mem_rgrubby <= mem_g[b0.mem_addr[9:2]];
        end else begin
            b0.mem_rdata   <= 32'hA5A5A5A5;
            b0.mem_rgrubby <= 1'b1;
            if (b0.mem_valid && b0.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (b0.mem_wmask[b]) mem[b0.mem_addr[9:2]][8*b +: 8] <= b0.mem_wdata[8*b +: 8];
                if (b0.mem_wmask != 4'h0) mem_g[b0.mem_addr[9:2]] <= b0.mem_wgrubby;
            end
        end
    end

    task automatic idle();
        b0.m0_valid = 0; b0.m0_write = 0; b0.m0_wmask = 0; b0.m0_wdata = 0; b0.m0_wgrubby = 0; b0.m0_addr = 0;
        b0.m1_valid = 0; b0.m1_write = 0; b0.m1_wmask = 0; b0.m1_wdata = 0; b0.m1_wgrubby = 0; b0.m1_addr = 0;
    endtask

    // One cycle: sample just after the falling edge, compare against the model, advance the model and the clock.
    task automatic tick();
        rsp_t        e;
        bit          has;
        logic        eg0, eg1, fg0, fg1;
        logic [69:0] exp_bus, got_bus;
        logic [65:0] exp_rd, got_rd;
        #2;
        has = sb.size() > 0;
        if (has) e = sb.pop_front();
        eg1 = !rst && b0.m1_valid && (!b0.m0_valid || wc0 == 4);
        eg0 = !rst && b0.m0_valid && !eg1;
        fg1 = !rst && b0.m1_valid && !b0.m0_valid;
        fg0 = !rst && b0.m0_valid && !fg1;
        obs_g1_u0 = b0.m1_ready;
        obs_g1_u1 = b1.m1_ready;
        checks++;
        if ({b0.m0_ready, b0.m1_ready, b0.mem_valid} !== {eg0, eg1, eg0 | eg1}) begin
            errors++;
            $display("FAIL grant_u0 t=%0t got r0/r1/mv=%b%b%b want %b%b%b", $time,
                     b0.m0_ready, b0.m1_ready, b0.mem_valid, eg0, eg1, eg0 | eg1);
        end
        checks++;
        if ({b1.m0_ready, b1.m1_ready, b1.mem_valid} !== {fg0, fg1, fg0 | fg1}) begin
            errors++;
            $display("FAIL grant_u1 t=%0t got r0/r1/mv=%b%b%b want %b%b%b", $time,
                     b1.m0_ready, b1.m1_ready, b1.mem_valid, fg0, fg1, fg0 | fg1);
        end
        exp_bus = eg1 ? {b0.m1_write, b0.m1_wmask, b0.m1_addr, b0.m1_wdata, b0.m1_wgrubby} :
                  eg0 ? {b0.m0_write, b0.m0_wmask, b0.m0_addr, b0.m0_wdata, b0.m0_wgrubby} : 70'h0;
        got_bus = {b0.mem_write, b0.mem_wmask, b0.mem_addr, b0.mem_wdata, b0.mem_wgrubby};
        checks++;
        if (got_bus !== exp_bus) begin
            errors++;
            $display("FAIL mem_bus t=%0t got %h want %h", $time, got_bus, exp_bus);
        end
        checks++;
        if ({b0.m0_rvalid, b0.m1_rvalid} !== {has && !e.port, has && e.port}) begin
            errors++;
            $display("FAIL rvalid t=%0t got %b%b want %b%b", $time, b0.m0_rvalid, b0.m1_rvalid,
                     has && !e.port, has && e.port);
        end
        exp_rd = !has ? 66'h0 : e.port ? {33'h0, e.data, e.grubby} : {e.data, e.grubby, 33'h0};
        got_rd = {b0.m0_rdata, b0.m0_rgrubby, b0.m1_rdata, b0.m1_rgrubby};
        checks++;
        if (got_rd !== exp_rd) begin
            errors++;
            $display("FAIL rdata t=%0t got %h want %h", $time, got_rd, exp_rd);
        end
        if (eg0 && !b0.m0_write) sb.push_back('{1'b0, ref_mem[b0.m0_addr[9:2]], ref_g[b0.m0_addr[9:2]]});
        if (eg1 && !b0.m1_write) sb.push_back('{1'b1, ref_mem[b0.m1_addr[9:2]], ref_g[b0.m1_addr[9:2]]});
        if (eg0 && b0.m0_write) begin
            for (int b = 0; b < 4; b++)
                if (b0.m0_wmask[b]) ref_mem[b0.m0_addr[9:2]][8*b +: 8] = b0.m0_wdata[8*b +: 8];
            if (b0.m0_wmask != 4'h0) ref_g[b0.m0_addr[9:2]] = b0.m0_wgrubby;
        end
        if (eg1 && b0.m1_write) begin
            for (int b = 0; b < 4; b++)
                if (b0.m1_wmask[b]) ref_mem[b0.m1_addr[9:2]][8*b +: 8] = b0.m1_wdata[8*b +: 8];
            if (b0.m1_wmask != 4'h0) ref_g[b0.m1_addr[9:2]] = b0.m1_wgrubby;
        end
        wc0 = (rst || eg1 || !b0.m1_valid) ? 0 : (wc0 < 4 ? wc0 + 1 : wc0);
        wc1 = 0;
        g0_m = eg0;
        g1_m = eg1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        b0.m0_valid = 1;
        b0.m1_valid = 1;
        b0.m0_addr = 32'h100;
        b0.m1_addr = 32'h104;
        repeat (2) tick();
        rst = 0;
        tick();
        idle();
        repeat (2) tick();
    endtask

    task automatic test_port0();
        b0.m0_valid = 1; b0.m0_write = 1; b0.m0_addr = 32'h100; b0.m0_wdata = 32'hDEADBEEF; b0.m0_wmask = 4'hF;
        tick();
        b0.m0_write = 0; b0.m0_wmask = 0; b0.m0_wdata = 0;
        tick();
        b0.m0_write = 1; b0.m0_wmask = 4'b0011; b0.m0_wdata = 32'h11112222; b0.m0_wgrubby = 1;
        tick();
        b0.m0_write = 0; b0.m0_wmask = 0; b0.m0_wdata = 0; b0.m0_wgrubby = 0;
        tick();
        idle();
        tick();
    endtask

    task automatic test_starvation();
        logic [19:0] pat0 = '0;
        logic [19:0] pat1 = '0;
        logic [19:0] want0;
        want0 = 20'b1000_0100_0010_0001_0000;
        b0.m0_valid = 1; b0.m0_addr = 32'h100;
        b0.m1_valid = 1; b0.m1_addr = 32'h204;
        for (int i = 0; i < 20; i++) begin
            tick();
            pat0[i] = obs_g1_u0;
            pat1[i] = obs_g1_u1;
        end
        checks++;
        if (pat0 !== want0) begin
            errors++;
            $display("FAIL starve_pattern got %b want %b", pat0, want0);
        end
        checks++;
        if (pat1 !== 20'h0) begin
            errors++;
            $display("FAIL no_guard_pattern got %b want %b", pat1, 20'h0);
        end
        b0.m0_valid = 0;
        tick();
        checks++;
        if (obs_g1_u1 !== 1'b1) begin
            errors++;
            $display("FAIL no_guard_release got %b want 1", obs_g1_u1);
        end
        idle();
        tick();
    endtask

    task automatic test_routing();
        b0.m1_valid = 1; b0.m1_addr = 32'h200;
        tick();
        idle();
        b0.m0_valid = 1; b0.m0_addr = 32'h204;
        tick();
        idle();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_read();
        b0.m1_valid = 1; b0.m1_addr = 32'h200;
        rst = 1;
        tick();
        b0.m1_write = 1; b0.m1_wmask = 4'hF; b0.m1_wdata = 32'hFFFFFFFF;
        tick();
        rst = 0;
        idle();
        tick();
        b0.m0_valid = 1; b0.m0_addr = 32'h200;
        tick();
        idle();
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!b0.m0_valid || g0_m) begin
                b0.m0_valid   = 1'($urandom_range(0, 3) != 0);
                b0.m0_write   = 1'($urandom_range(0, 2) == 0);
                b0.m0_wmask   = 4'($urandom_range(0, 15));
                b0.m0_wdata   = $urandom;
                b0.m0_wgrubby = 1'($urandom_range(0, 1));
                b0.m0_addr    = 32'h100 + 32'(4 * $urandom_range(0, 15));
            end
            if (!b0.m1_valid || g1_m) begin
                b0.m1_valid   = 1'($urandom_range(0, 1));
                b0.m1_write   = 1'($urandom_range(0, 2) == 0);
                b0.m1_wmask   = 4'($urandom_range(0, 15));
                b0.m1_wdata   = $urandom;
                b0.m1_wgrubby = 1'($urandom_range(0, 1));
                b0.m1_addr    = 32'h100 + 32'(4 * $urandom_range(0, 15));
            end
        end
        idle();
        repeat (2) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0;
            ref_g[i]   = 1'b0;
        end
        ref_mem[8'h80] = 32'h12345678;
        ref_g[8'h80]   = 1'b1;
        ref_mem[8'h81] = 32'h0BADF00D;
        idle();
        @(negedge clk);
        test_reset();
        test_port0();
        test_starvation();
        test_routing();
        test_reset_mid_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
